// File: rtl/regfile_scoreboard.sv
// Integer register file with two read ports, a debug read port, two writeback ports and a busy scoreboard; define REGFILE_BYPASS_EN to forward writebacks.
// Latency: reads and stalls are combinational; writes and busy updates take effect at the rising edge.
// Backpressure: raw_stall/waw_stall are advisory; the issue stage must hold issue_en low while waw_stall is high.
module regfile_scoreboard #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    rs1,
  input  logic [ADDR_W-1:0]    rs2,
  output logic [WORD_SIZE-1:0] rv1,
  output logic [WORD_SIZE-1:0] rv2,
  input  logic [ADDR_W-1:0]    debug_reg,
  output logic [WORD_SIZE-1:0] debug_reg_out,
  input  logic                 issue_en,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic                 wb0_en,
  input  logic [ADDR_W-1:0]    wb0_rd,
  input  logic [WORD_SIZE-1:0] wb0_data,
  input  logic                 wb1_en,
  input  logic [ADDR_W-1:0]    wb1_rd,
  input  logic [WORD_SIZE-1:0] wb1_data,
  input  logic                 flush,
  output logic                 raw_stall,
  output logic                 waw_stall,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]  busy;

  // Entry 0 is only ever written by reset, so it reads zero and is never busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb1_en && wb1_rd == ADDR_W'(i)) begin
          regs[i] <= wb1_data;
        end else if (wb0_en && wb0_rd == ADDR_W'(i)) begin
          regs[i] <= wb0_data;
        end

        if (flush) begin
          busy[i] <= 1'b0;
        end else if (issue_en && issue_rd == ADDR_W'(i)) begin
          busy[i] <= 1'b1;
        end else if ((wb0_en && wb0_rd == ADDR_W'(i)) ||
                     (wb1_en && wb1_rd == ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  logic rs1_busy, rs2_busy;
  logic rs1_resolved, rs2_resolved;
  logic issue_resolved;

  assign rs1_busy = (rs1 != '0) && busy[rs1];
  assign rs2_busy = (rs2 != '0) && busy[rs2];

  assign issue_resolved = (wb0_en && wb0_rd == issue_rd) ||
                          (wb1_en && wb1_rd == issue_rd);

`ifdef REGFILE_BYPASS_EN
  logic wb0_hit1, wb1_hit1, wb0_hit2, wb1_hit2;

  // Forwarding is gated by reset so outputs read zero while reset is held.
  assign wb0_hit1 = rst && wb0_en && (rs1 != '0) && (wb0_rd == rs1);
  assign wb1_hit1 = rst && wb1_en && (rs1 != '0) && (wb1_rd == rs1);
  assign wb0_hit2 = rst && wb0_en && (rs2 != '0) && (wb0_rd == rs2);
  assign wb1_hit2 = rst && wb1_en && (rs2 != '0) && (wb1_rd == rs2);

  always_comb begin
    rv1 = regs[rs1];
    if (wb1_hit1) begin
      rv1 = wb1_data;
    end else if (wb0_hit1) begin
      rv1 = wb0_data;
    end
  end

  always_comb begin
    rv2 = regs[rs2];
    if (wb1_hit2) begin
      rv2 = wb1_data;
    end else if (wb0_hit2) begin
      rv2 = wb0_data;
    end
  end

  assign rs1_resolved = wb0_hit1 || wb1_hit1;
  assign rs2_resolved = wb0_hit2 || wb1_hit2;
`else
  assign rv1 = regs[rs1];
  assign rv2 = regs[rs2];

  // Without forwarding a source stays stalled through its writeback cycle.
  assign rs1_resolved = 1'b0;
  assign rs2_resolved = 1'b0;
`endif

  assign debug_reg_out = regs[debug_reg];

  assign raw_stall = (rs1_busy && !rs1_resolved) || (rs2_busy && !rs2_resolved);
  assign waw_stall = issue_en && (issue_rd != '0) && busy[issue_rd] && !issue_resolved;
  assign busy_vec  = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, debug_reg, issue_rd, wb0_rd, wb1_rd;
  logic [31:0] rv1, rv2, debug_reg_out, wb0_data, wb1_data;
  logic        issue_en, wb0_en, wb1_en, flush;
  logic        raw_stall, waw_stall;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  regfile_scoreboard #(.WORD_SIZE(32), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .rs1(rs1), .rs2(rs2), .rv1(rv1), .rv2(rv2),
    .debug_reg(debug_reg), .debug_reg_out(debug_reg_out),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb0_en(wb0_en), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .flush(flush), .raw_stall(raw_stall), .waw_stall(waw_stall),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    issue_en = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rs1 = 5'd5; rs2 = 5'd0; debug_reg = 5'd5; issue_rd = 5'd0;
    wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF; wb1_rd = 5'd0; wb1_data = 32'h0;
    issue_en = 1'b0; wb0_en = 1'b1; wb1_en = 1'b0; flush = 1'b0;

    // Reset held with a pending write to r5
    tick(); tick(); #1;
    check("rst_rv1", rv1, 32'h0);
    check("rst_dbg", debug_reg_out, 32'h0);
    check("rst_busy", busy_vec, 32'h0);
    check("rst_raw", {31'b0, raw_stall}, 32'h0);
    check("rst_waw", {31'b0, waw_stall}, 32'h0);

    rst = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
    check("rel_rv1", rv1, 32'hDEADBEEF);
`else
    check("rel_rv1", rv1, 32'h0);
`endif
    check("rel_dbg", debug_reg_out, 32'h0);
    tick(); idle(); #1;
    check("wr_rv1", rv1, 32'hDEADBEEF);
    check("wr_dbg", debug_reg_out, 32'hDEADBEEF);

    // r0 ignores writes and claims
    wb0_en = 1'b1; wb0_rd = 5'd0; wb0_data = 32'h1234;
    issue_en = 1'b1; issue_rd = 5'd0; rs1 = 5'd0; #1;
    check("r0_waw", {31'b0, waw_stall}, 32'h0);
    check("r0_rv1_now", rv1, 32'h0);
    tick(); idle(); #1;
    check("r0_rv1", rv1, 32'h0);
    check("r0_busy", busy_vec, 32'h0);
    check("r0_raw", {31'b0, raw_stall}, 32'h0);

    // RAW on r7, WAW probe, then load writeback
    issue_en = 1'b1; issue_rd = 5'd7; #1;
    check("iss7_waw", {31'b0, waw_stall}, 32'h0);
    tick(); idle(); rs1 = 5'd7; #1;
    check("raw_busy", busy_vec, 32'h0000_0080);
    check("raw_stall", {31'b0, raw_stall}, 32'h1);
    issue_en = 1'b1; issue_rd = 5'd7; #1;
    check("waw_stall", {31'b0, waw_stall}, 32'h1);
    issue_en = 1'b0;
    wb1_en = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h0000A5A5; #1;
`ifdef REGFILE_BYPASS_EN
    check("raw_wb_stall", {31'b0, raw_stall}, 32'h0);
    check("raw_wb_rv1", rv1, 32'h0000A5A5);
`else
    check("raw_wb_stall", {31'b0, raw_stall}, 32'h1);
    check("raw_wb_rv1", rv1, 32'h0);
`endif
    tick(); idle(); #1;
    check("raw_after_stall", {31'b0, raw_stall}, 32'h0);
    check("raw_after_rv1", rv1, 32'h0000A5A5);
    check("raw_after_busy", busy_vec, 32'h0);

    // Dual write to r3: port 1 wins
    wb0_en = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h1111;
    wb1_en = 1'b1; wb1_rd = 5'd3; wb1_data = 32'h2222; rs2 = 5'd3; #1;
`ifdef REGFILE_BYPASS_EN
    check("dual_byp_rv2", rv2, 32'h2222);
`else
    check("dual_byp_rv2", rv2, 32'h0);
`endif
    tick(); idle(); #1;
    check("dual_rv2", rv2, 32'h2222);

    // Issue and writeback to busy r9 in the same cycle
    issue_en = 1'b1; issue_rd = 5'd9;
    tick(); idle(); #1;
    check("col_busy_pre", busy_vec, 32'h0000_0200);
    issue_en = 1'b1; issue_rd = 5'd9;
    wb0_en = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h55; #1;
    check("col_waw", {31'b0, waw_stall}, 32'h0);
    tick(); idle(); rs1 = 5'd9; debug_reg = 5'd9; #1;
    check("col_busy", busy_vec, 32'h0000_0200);
    check("col_rv1", rv1, 32'h55);
    check("col_dbg", debug_reg_out, 32'h55);
    check("col_raw", {31'b0, raw_stall}, 32'h1);

    // Flush beats issue; writes in the flush cycle still complete
    issue_en = 1'b1; issue_rd = 5'd4; tick();
    issue_rd = 5'd6; tick(); idle(); #1;
    check("fl_busy_pre", busy_vec, 32'h0000_0250);
    issue_en = 1'b1; issue_rd = 5'd8; flush = 1'b1;
    wb0_en = 1'b1; wb0_rd = 5'd10; wb0_data = 32'h77;
    tick(); idle(); debug_reg = 5'd10; #1;
    check("fl_busy", busy_vec, 32'h0);
    check("fl_raw", {31'b0, raw_stall}, 32'h0);
    check("fl_rv1", rv1, 32'h55);
    check("fl_rv2", rv2, 32'h2222);
    check("fl_wb", debug_reg_out, 32'h77);

    // Reset mid-operation discards a pending writeback
    wb0_en = 1'b1; wb0_rd = 5'd11; wb0_data = 32'hCAFE;
    issue_en = 1'b1; issue_rd = 5'd12; rst = 1'b0;
    tick(); idle(); rst = 1'b1; debug_reg = 5'd11; rs1 = 5'd5; #1;
    check("mrst_r11", debug_reg_out, 32'h0);
    check("mrst_r5", rv1, 32'h0);
    check("mrst_busy", busy_vec, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the pipelined core: NUM_REGS × WORD_SIZE storage, two combinational read ports, a debug read port and two writeback ports, with a per-register busy scoreboard. The issue stage uses it to detect RAW and WAW hazards; writeback clears them. It sits between decode/issue and the ALU and load writeback paths. It replaces the single-write-port file; register 0 stays hardwired to zero.

## Interface
- WORD_SIZE, 32, data width of every register.
- NUM_REGS, 32, number of architectural registers; power of two, 2..64.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- rs1, rs2  in  ADDR_W  read addresses.
- rv1, rv2  out  WORD_SIZE  read data.
- debug_reg  in  ADDR_W  debug read address; debug_reg_out  out  WORD_SIZE  data, never bypassed.
- issue_en  in  1  instruction issues this cycle and claims issue_rd.
- issue_rd  in  ADDR_W  destination of the issuing instruction.
- wb0_en, wb1_en  in  1  writeback strobes (port 0 ALU, port 1 load).
- wb0_rd, wb1_rd  in  ADDR_W  writeback destinations.
- wb0_data, wb1_data  in  WORD_SIZE  writeback data.
- flush  in  1  synchronous clear of all busy bits (pipeline flush); register data untouched.
- raw_stall  out  1  rs1 or rs2 refers to an unresolved busy register.
- waw_stall  out  1  issue_rd is busy and not resolved this cycle.
- busy_vec  out  NUM_REGS  current busy bits, bit i = register i.

## Operation
- Storage: registers[0] always reads 0; writes and issue claims to address 0 are ignored; busy[0] is constantly 0.
- Write: wbN_en with wbN_rd≠0 writes wbN_data at the edge. Both ports to the same nonzero address in one cycle: port 1 data written.
- Busy bit i, next-state priority: flush → 0; else issue_en && issue_rd==i → 1; else any wbN_en to i → 0; else hold. An issue and a writeback to the same register in the same cycle leave busy set (new producer owns it); data is still written.
- waw_stall = issue_en && issue_rd≠0 && busy[issue_rd] && no writeback to issue_rd this cycle. The block still applies the claim if issue_en is asserted; the issue stage must hold issue_en low while waw_stall is high.
- raw_stall = for each of rs1/rs2 ≠0: busy[rsX] and not resolved this cycle. "Resolved" means a writeback to rsX this cycle when REGFILE_BYPASS_EN is defined; without it, never resolved in the same cycle.
- raw_stall and waw_stall are combinational and do not depend on issue_en for raw_stall.

## Timing
- Reset (rst low, asynchronous): all registers 0, all busy bits 0; hence rv1=rv2=debug_reg_out=0, raw_stall=waw_stall=0, busy_vec=0 while reset is held and after release. Reset mid-operation discards pending writebacks in that cycle.
- Reads: zero-cycle combinational from array (or bypass). Write visible on rv1/rv2 the cycle after the edge without bypass; same cycle with bypass.
- Busy bit set visible one cycle after the issuing edge; cleared visible one cycle after writeback edge.
- flush takes priority over a simultaneous issue_en; writes in the flush cycle still complete.

## Configuration
- REGFILE_BYPASS_EN defined: rv1/rv2 forward wbN_data when wbN_en and wbN_rd equals the read address (≠0), port 1 over port 0; raw_stall suppressed for that operand in that cycle. debug_reg_out never forwarded.
- Not defined: no forwarding; rv1/rv2 read only the array; a busy source stalls through its writeback cycle and releases the cycle after.

## Test plan
- Reset: hold rst low, drive wb0 to r5=0xDEADBEEF -> rv1(rs1=5)=0, busy_vec=0; after release write lands only on later edges.
- r0: wb0 r0=0x1234, issue_en r0 -> rv1(rs1=0)=0, busy_vec[0]=0, no stalls.
- RAW: issue r7, next cycle rs1=7 -> raw_stall=1; wb1 r7=0xA5A5 -> with bypass rv1=0xA5A5 and raw_stall=0 that cycle; without bypass raw_stall=1 that cycle, 0 and rv1=0xA5A5 next cycle.
- Dual write conflict: wb0 r3=0x1111, wb1 r3=0x2222 same cycle -> r3=0x2222; bypass rv2(rs2=3)=0x2222.
- Issue/writeback collision: r9 busy, same cycle wb0 r9=0x55 and issue r9 -> waw_stall=0, r9=0x55, busy[9] stays 1.
- Flush: busy r4,r6 and issue r8 with flush -> busy_vec=0 next cycle, register contents unchanged.
